// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: parametrised SPART serial receiver feeding a first-word-fall-through FIFO.
// Frames carry 5..9 data bits (LSB first), optional even/odd parity and 1 or 2 stop bits.
// Each stored word carries parity/framing error tags; a sticky overrun flag records drops.
// Optional build macro: SPART_RX_MAJORITY_EN selects 2-of-3 majority sampling per bit.
module spart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [15:0]                   divisor_buffer,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits2,
  input  logic                          rd_en,
  input  logic                          clr_ovr,
  output logic                          rda,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 meta_q, rxs_q;
  logic [15:0]          div_q, div_d, cnt_q, cnt_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [BCW-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, second_q, second_d;
  logic                 push, push_ferr;
  logic                 at_zero, sample_evt, sample_bit, par_en;
  logic [15:0]          eff_div;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 pop, full, wr, drop;
  logic [EW-1:0]        head;

  // Divisors below 3 are clamped so the half-period and majority window always fit.
  assign eff_div = (divisor_buffer < 16'd3) ? 16'd3 : divisor_buffer;
  assign at_zero = (state_q != S_IDLE) && (cnt_q == 16'd0);
  assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);

`ifdef SPART_RX_MAJORITY_EN
  logic s1_q, s0_q, pend_q;

  // Capture rxs at counter 1 and 0; the third vote is rxs one cycle after the counter hits 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      if (cnt_q == 16'd1) s1_q <= rxs_q;
      if (at_zero)        s0_q <= rxs_q;
      pend_q <= at_zero;
    end
  end

  assign sample_evt = pend_q;
  assign sample_bit = (s1_q & s0_q) | (s1_q & rxs_q) | (s0_q & rxs_q);
`else
  assign sample_evt = at_zero;
  assign sample_bit = rxs_q;
`endif

  // Two-flop synchroniser plus receiver control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q   <= 1'b1;
      rxs_q    <= 1'b1;
      state_q  <= S_IDLE;
      div_q    <= 16'd3;
      cnt_q    <= 16'd0;
      par_q    <= 2'b00;
      stop2_q  <= 1'b0;
      bitcnt_q <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      meta_q   <= rxd;
      rxs_q    <= meta_q;
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      bitcnt_q <= bitcnt_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      second_q <= second_d;
    end
  end

  // Data shift register; contents only matter once a full frame has been assembled.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Next-state logic: bit timing, frame sequencing and push generation.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    second_d  = second_q;
    push      = 1'b0;
    push_ferr = ferr_q | ~sample_bit;
    if (state_q != S_IDLE) cnt_d = (cnt_q == 16'd0) ? div_q : cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d  = S_START;
          div_d    = eff_div;
          par_d    = parity_mode;
          stop2_d  = stop_bits2;
          cnt_d    = eff_div >> 1;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          second_d = 1'b0;
        end
      end
      S_START: begin
        if (sample_evt) begin
          if (!sample_bit) begin
            state_d  = S_DATA;
            bitcnt_d = BCW'(DATA_BITS);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample_evt) begin
          shreg_d  = {sample_bit, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q - BCW'(1);
          if (bitcnt_q == BCW'(1)) state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_evt) begin
          perr_d  = ((^shreg_q) ^ sample_bit) != (par_q == 2'b10);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_evt) begin
          ferr_d = push_ferr;
          if (stop2_q && !second_q) begin
            second_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop  = rd_en && (count_q != '0);
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  // FIFO pointer, occupancy and overrun next-state; a drop beats a simultaneous clear.
  always_comb begin
    wptr_d    = wr  ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (!wr && pop) count_d = count_q - CW'(1);
    if (drop)         overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage: {perr, ferr, data} per entry.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= {perr_q, push_ferr, shreg_q};
  end

  assign head       = mem_q[rptr_q];
  assign rda        = (count_q != '0);
  assign rx_data    = rda ? head[DATA_BITS-1:0] : '0;
  assign rx_ferr    = rda ? head[DATA_BITS]     : 1'b0;
  assign rx_perr    = rda ? head[DATA_BITS+1]   : 1'b0;
  assign overrun    = overrun_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo (DATA_BITS=8, FIFO_DEPTH=4).
module tb_spart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] divisor_buffer = 16'd15;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits2 = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        rda;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, overrun;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  spart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .divisor_buffer(divisor_buffer),
    .parity_mode(parity_mode), .stop_bits2(stop_bits2), .rd_en(rd_en),
    .clr_ovr(clr_ovr), .rda(rda), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .overrun(overrun), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One bit slot of per clocks; optional 1-clk inverted glitch at the slot centre.
  task automatic bit_out(input logic v, input int per, input logic glitch);
    rxd = v;
    if (glitch) begin
      repeat (8) @(negedge clk);
      rxd = ~v;
      @(negedge clk);
      rxd = v;
      repeat (per - 9) @(negedge clk);
    end else begin
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic s2val, input int per, input int gidx);
    @(negedge clk);
    bit_out(1'b0, per, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i], per, gidx == i);
    if (has_par) bit_out(pbit, per, 1'b0);
    bit_out(1'b1, per, 1'b0);
    if (stop_bits2) bit_out(s2val, per, 1'b0);
    rxd = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  task automatic pop_word();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rda",     32'(rda), 32'd0);
    chk("rst_data",    32'(rx_data), 32'd0);
    chk("rst_perr",    32'(rx_perr), 32'd0);
    chk("rst_ferr",    32'(rx_ferr), 32'd0);
    chk("rst_ovr",     32'(overrun), 32'd0);
    chk("rst_count",   32'(fifo_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 basic frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1);
    chk("t1_rda",   32'(rda), 32'd1);
    chk("t1_data",  32'(rx_data), 32'hA5);
    chk("t1_perr",  32'(rx_perr), 32'd0);
    chk("t1_ferr",  32'(rx_ferr), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd1);
    pop_word();
    chk("t1_pop_rda",   32'(rda), 32'd0);
    chk("t1_pop_count", 32'(fifo_count), 32'd0);
    pop_word();
    chk("empty_pop_count", 32'(fifo_count), 32'd0);

    // Parity: 0x3C has even weight
    parity_mode = 2'b01;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1);
    chk("t2_even_bad_data", 32'(rx_data), 32'h3C);
    chk("t2_even_bad_perr", 32'(rx_perr), 32'd1);
    pop_word();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1);
    chk("t2_even_ok_perr", 32'(rx_perr), 32'd0);
    chk("t2_even_ok_rda",  32'(rda), 32'd1);
    pop_word();
    parity_mode = 2'b10;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1);
    chk("t2_odd_ok_perr", 32'(rx_perr), 32'd0);
    pop_word();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1);
    chk("t2_odd_bad_perr", 32'(rx_perr), 32'd1);
    pop_word();
    parity_mode = 2'b00;

    // Short low pulse is rejected as a false start
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_rda",   32'(rda), 32'd0);
    chk("t3_count", 32'(fifo_count), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1);
    chk("t3_next_data", 32'(rx_data), 32'h5A);
    pop_word();

    // Overrun: five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 16, -1);
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_ovr",   32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_pop_data", 32'(rx_data), 32'(i));
      pop_word();
    end
    chk("t4_empty",    32'(fifo_count), 32'd0);
    chk("t4_ovr_stk",  32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("t4_ovr_clr",  32'(overrun), 32'd0);

    // Two stop bits, second one low
    stop_bits2 = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 16, -1);
    chk("t5_count", 32'(fifo_count), 32'd1);
    chk("t5_data",  32'(rx_data), 32'h55);
    chk("t5_ferr",  32'(rx_ferr), 32'd1);
    pop_word();
    repeat (40) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 16, -1);
    chk("t5_ok_count", 32'(fifo_count), 32'd1);
    chk("t5_ok_ferr",  32'(rx_ferr), 32'd0);
    pop_word();
    stop_bits2 = 1'b0;

    // Divisor below 3 clamps to 3 (4-clk bit period)
    divisor_buffer = 16'd1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 4, -1);
    chk("div_min_data",  32'(rx_data), 32'hC3);
    chk("div_min_count", 32'(fifo_count), 32'd1);
    pop_word();
    divisor_buffer = 16'd15;

    // Reset in the middle of a 0xFF frame
    @(negedge clk);
    bit_out(1'b0, 16, 1'b0);
    bit_out(1'b1, 16, 1'b0);
    bit_out(1'b1, 8, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 16, -1);
    chk("t6_count", 32'(fifo_count), 32'd1);
    chk("t6_data",  32'(rx_data), 32'h12);
    pop_word();

`ifdef SPART_RX_MAJORITY_EN
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 2);
    chk("maj_glitch_data", 32'(rx_data), 32'hA5);
    pop_word();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
